// File: rtl/alu_control_unit_if.sv
// ----------------------------------------------------------------------------
// alu_control_unit_if
// Bundles the signals between the ALU sequencer and its surroundings.
//   master : the sequencer (alu_control_unit)
//            in : run, rom_data, CF_in, ZF_in
//            out: rom_addr, f, write_cz, load_a, load_b, imm_en, imm,
//                 out_strobe, halted
//   slave  : the surrounding datapath / ROM / testbench (directions mirrored)
// ----------------------------------------------------------------------------
interface alu_control_unit_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [PC_W-1:0] rom_addr;
    logic [7:0]      rom_data;
    logic            CF_in;
    logic            ZF_in;
    logic [2:0]      f;
    logic            write_cz;
    logic            load_a;
    logic            load_b;
    logic            imm_en;
    logic [7:0]      imm;
    logic            out_strobe;
    logic            halted;

    modport master (
        input  run, rom_data, CF_in, ZF_in,
        output rom_addr, f, write_cz, load_a, load_b, imm_en, imm,
               out_strobe, halted
    );

    modport slave (
        output run, rom_data, CF_in, ZF_in,
        input  rom_addr, f, write_cz, load_a, load_b, imm_en, imm,
               out_strobe, halted
    );
endinterface

// File: rtl/alu_control_unit.sv
// ----------------------------------------------------------------------------
// alu_control_unit
// Instruction sequencer for the 8-bit CPU. Fetches 8-bit instructions from a
// synchronous-read program ROM, decodes them and issues one cycle of ALU /
// register-file strobes per instruction. Conditional jumps consume the ALU's
// registered carry/zero flags.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_control_unit_if.master (run, ROM address/data, flags in,
//          ALU function select, strobes, immediate, halted)
// Instruction set (IR[7:5]):
//   000 ALU f=IR[4:2] dst=IR[1] cz=IR[0] | 001 LDI dst=IR[0], +imm
//   010 JMP imm | 011 JC imm | 100 JZ imm | 101 OUT | 110 NOP | 111 HLT
// ----------------------------------------------------------------------------
module alu_control_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    alu_control_unit_if.master  bus
);

    localparam logic [2:0] OP_ALU = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_JMP = 3'b010;
    localparam logic [2:0] OP_JC  = 3'b011;
    localparam logic [2:0] OP_JZ  = 3'b100;
    localparam logic [2:0] OP_OUT = 3'b101;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_OP,
        S_OPERAND,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc,    w_pc_next;
    logic [7:0]      r_ir,    w_ir_next;
    logic [7:0]      r_imm,   w_imm_next;

    logic [2:0]      w_f;
    logic            w_write_cz, w_load_a, w_load_b, w_imm_en, w_out_strobe;

    // In DECODE the opcode is still on the ROM bus (IR loads at the end of
    // this cycle), so the branch decision looks at rom_data directly.
    logic [2:0]      w_dec_op;
    logic            w_dec_two_byte;
    logic [2:0]      w_ir_op;

    assign w_dec_op       = bus.rom_data[7:5];
    assign w_dec_two_byte = (w_dec_op == OP_LDI) || (w_dec_op == OP_JMP) ||
                            (w_dec_op == OP_JC)  || (w_dec_op == OP_JZ);
    assign w_ir_op        = r_ir[7:5];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_imm   <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_imm   <= w_imm_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_imm_next   = r_imm;
        w_f          = 3'b000;
        w_write_cz   = 1'b0;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_imm_en     = 1'b0;
        w_out_strobe = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                w_ir_next = bus.rom_data;
                w_pc_next = r_pc + 1'b1;
                if (w_dec_two_byte)          w_state_next = S_FETCH_OP;
                else if (w_dec_op == OP_HLT) w_state_next = S_HALT;
                else                         w_state_next = S_EXEC;
            end
            S_FETCH_OP: begin
                w_state_next = S_OPERAND;
            end
            S_OPERAND: begin
                w_imm_next   = bus.rom_data;
                w_pc_next    = r_pc + 1'b1;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                case (w_ir_op)
                    OP_ALU: begin
                        w_f        = r_ir[4:2];
                        w_write_cz = r_ir[0];
                        w_load_a   = ~r_ir[1];
                        w_load_b   = r_ir[1];
                    end
                    OP_LDI: begin
                        // f=001 passes bBus straight through to cBus.
                        w_f      = 3'b001;
                        w_imm_en = 1'b1;
                        w_load_a = ~r_ir[0];
                        w_load_b = r_ir[0];
                    end
                    OP_JMP: w_pc_next = PC_W'(r_imm);
                    OP_JC:  if (bus.CF_in) w_pc_next = PC_W'(r_imm);
                    OP_JZ:  if (bus.ZF_in) w_pc_next = PC_W'(r_imm);
                    OP_OUT: w_out_strobe = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.rom_addr   = r_pc;
    assign bus.imm        = r_imm;
    assign bus.f          = w_f;
    assign bus.write_cz   = w_write_cz;
    assign bus.load_a     = w_load_a;
    assign bus.load_b     = w_load_b;
    assign bus.imm_en     = w_imm_en;
    assign bus.out_strobe = w_out_strobe;
    assign bus.halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_alu_control_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_control_unit
// Directed programs plus a random program run through alu_control_unit.
// The reference is an instruction-level model: it walks the ROM one
// instruction at a time, knows each instruction's length (1 or 2 bytes ->
// 3 or 5 cycles) and what the single EXEC cycle must show.
// ----------------------------------------------------------------------------
module tb_alu_control_unit;

    logic clk;
    logic rst;

    alu_control_unit_if #(.PC_W(8)) bus ();

    alu_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read program ROM.
    logic [7:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         last_exec_cyc = 0;
    logic [7:0] m_pc;
    logic [7:0] m_imm;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {f, write_cz, load_a, load_b, imm_en, out_strobe, halted}
    function automatic logic [15:0] ctl_vec();
        return 16'({bus.f, bus.write_cz, bus.load_a, bus.load_b,
                    bus.imm_en, bus.out_strobe, bus.halted});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        tick();
        chk("rst_ctl",  ctl_vec(), 16'h0);
        chk("rst_addr", 16'(bus.rom_addr), 16'h00);
        chk("rst_imm",  16'(bus.imm), 16'h00);
        rst   = 1'b0;
        m_pc  = 8'h00;
        m_imm = 8'h00;
    endtask

    // Entered in the FETCH cycle; leaves in the next FETCH cycle (or HALT).
    task automatic run_instr(input logic cf, input logic zf);
        logic [7:0]  ir, opd, pc1;
        logic [2:0]  op, ef;
        logic        two, wcz, la, lb, ie, os;
        bus.CF_in = cf;
        bus.ZF_in = zf;
        chk("fetch_addr", 16'(bus.rom_addr), 16'(m_pc));
        chk("fetch_ctl",  ctl_vec(), 16'h0);
        ir   = rom[m_pc];
        m_pc = m_pc + 8'd1;
        pc1  = m_pc;
        op   = ir[7:5];
        two  = (op >= 3'd1) && (op <= 3'd4);
        opd  = 8'h00;
        if (two) begin
            opd  = rom[m_pc];
            m_pc = m_pc + 8'd1;
        end
        tick();                                  // DECODE
        chk("decode_ctl", ctl_vec(), 16'h0);
        if (op == 3'd7) begin
            tick();                              // HALT
            chk("halt_flag", 16'(bus.halted), 16'h1);
            chk("halt_addr", 16'(bus.rom_addr), 16'(m_pc));
            return;
        end
        if (two) begin
            tick();                              // FETCH_OP
            chk("fop_addr", 16'(bus.rom_addr), 16'(pc1));
            tick();                              // OPERAND
            chk("opnd_ctl", ctl_vec(), 16'h0);
            m_imm = opd;
        end
        tick();                                  // EXEC
        last_exec_cyc = cyc;
        ef = 3'd0; wcz = 0; la = 0; lb = 0; ie = 0; os = 0;
        case (op)
            3'd0: begin ef = ir[4:2]; wcz = ir[0]; la = !ir[1]; lb = ir[1]; end
            3'd1: begin ef = 3'd1; ie = 1; la = !ir[0]; lb = ir[0]; end
            3'd2: m_pc = m_imm;
            3'd3: if (cf) m_pc = m_imm;
            3'd4: if (zf) m_pc = m_imm;
            3'd5: os = 1;
            default: ;
        endcase
        chk("exec_ctl", ctl_vec(), 16'({ef, wcz, la, lb, ie, os, 1'b0}));
        chk("exec_imm", 16'(bus.imm), 16'(m_imm));
        tick();                                  // next FETCH
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    initial begin
        int first_cyc;
        clk = 1'b0;
        rst = 1'b1;
        bus.run   = 1'b0;
        bus.CF_in = 1'b0;
        bus.ZF_in = 1'b0;
        clear_rom();

        // Load and add, with latency check.
        rom[0] = 8'h20; rom[1] = 8'h05; rom[2] = 8'h21; rom[3] = 8'h03; rom[4] = 8'h11;
        do_reset();
        bus.run = 1'b1;
        tick();
        first_cyc = cyc;
        run_instr(1'b0, 1'b0);
        run_instr(1'b0, 1'b0);
        run_instr(1'b0, 1'b0);
        chk("latency13", 16'(last_exec_cyc - first_cyc + 1), 16'd13);

        // Jumps: JZ/JC taken and not taken, then JMP FF -> NOP -> wrap to 0.
        clear_rom();
        rom[8'h00] = 8'h40; rom[8'h01] = 8'h10;
        rom[8'h10] = 8'h80; rom[8'h11] = 8'h50;
        rom[8'h12] = 8'h60; rom[8'h13] = 8'h30;
        rom[8'h14] = 8'h80; rom[8'h15] = 8'h40;
        rom[8'h40] = 8'h60; rom[8'h41] = 8'h20;
        rom[8'h20] = 8'h40; rom[8'h21] = 8'hFF;
        rom[8'hFF] = 8'hC0;
        do_reset();
        bus.run = 1'b1;
        tick();
        run_instr(1'b1, 1'b1);                   // JMP 10
        run_instr(1'b1, 1'b0);                   // JZ not taken -> 12
        chk("jz_nt_addr", 16'(bus.rom_addr), 16'h12);
        run_instr(1'b0, 1'b1);                   // JC not taken -> 14
        chk("jc_nt_addr", 16'(bus.rom_addr), 16'h14);
        run_instr(1'b0, 1'b1);                   // JZ taken -> 40
        chk("jz_t_addr", 16'(bus.rom_addr), 16'h40);
        run_instr(1'b1, 1'b0);                   // JC taken -> 20
        chk("jc_t_addr", 16'(bus.rom_addr), 16'h20);
        run_instr(1'b0, 1'b0);                   // JMP FF
        run_instr(1'b0, 1'b0);                   // NOP at FF
        chk("wrap_addr", 16'(bus.rom_addr), 16'h00);

        // OUT then HLT; halt must hold against run toggling.
        clear_rom();
        rom[0] = 8'hA0; rom[1] = 8'hE0;
        do_reset();
        bus.run = 1'b1;
        tick();
        run_instr(1'b0, 1'b0);
        run_instr(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.run = 1'($urandom_range(1));
            tick();
            chk("halt_hold_ctl",  ctl_vec(), 16'h1);
            chk("halt_hold_addr", 16'(bus.rom_addr), 16'h02);
        end

        // Reset during the EXEC of ALU op 11.
        clear_rom();
        rom[0] = 8'h11;
        do_reset();
        bus.run = 1'b1;
        tick();                                  // FETCH
        tick();                                  // DECODE
        tick();                                  // EXEC
        chk("mid_exec_ctl", ctl_vec(), 16'({3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst = 1'b1;
        bus.run = 1'b0;
        tick();
        chk("mid_rst_ctl",  ctl_vec(), 16'h0);
        chk("mid_rst_addr", 16'(bus.rom_addr), 16'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_ctl",  ctl_vec(), 16'h0);
            chk("idle_addr", 16'(bus.rom_addr), 16'h00);
        end
        m_pc = 8'h00;
        m_imm = 8'h00;
        bus.run = 1'b1;
        tick();
        run_instr(1'b0, 1'b0);

        // Random program (no HLT) with random flags.
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($urandom);
            if (rom[i][7:5] == 3'b111) rom[i][7:5] = 3'b110;
        end
        do_reset();
        bus.run = 1'b1;
        tick();
        for (int i = 0; i < 80; i++)
            run_instr(1'($urandom_range(1)), 1'($urandom_range(1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Instruction sequencer that drives the ALU from the opposite side of its interface.
- Fetches 8-bit instructions from a synchronous-read program ROM and decodes them.
- Issues the ALU function select, flag-write enable and register-load strobes, then consumes the registered carry/zero flags for conditional jumps.
- Sits between the program ROM, the A/B register file and the ALU in the 8-bit CPU.

Parameters:
- PC_W, 8, program counter / ROM address width.
- RESET_PC, 8'h00, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start request; sampled only in IDLE.
- rom_addr  output  PC_W  ROM address (equals pc register).
- rom_data  input  8  ROM read data, valid one cycle after rom_addr.
- CF_in  input  1  registered carry flag from the ALU.
- ZF_in  input  1  registered zero flag from the ALU.
- f  output  3  ALU function select.
- write_cz  output  1  ALU flag register write enable.
- load_a  output  1  load cBus into register A.
- load_b  output  1  load cBus into register B.
- imm_en  output  1  drive imm onto bBus instead of register B.
- imm  output  8  immediate operand.
- out_strobe  output  1  one-cycle pulse: external output latch captures register A.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (rst=1 at posedge) from any state, including mid-instruction:
  - State=IDLE, pc=RESET_PC, IR=0.
  - f=000, imm=0, and all strobes (write_cz, load_a, load_b, imm_en, out_strobe) = 0.
  - halted=0.
- Encoding: IR[7:5]=op.
  - 000 ALU: f=IR[4:2], dst=IR[1] (0=A, 1=B), cz=IR[0].
  - 001 LDI: dst=IR[0]; two-byte.
  - 010 JMP: two-byte.
  - 011 JC: two-byte.
  - 100 JZ: two-byte.
  - 101 OUT.
  - 110 NOP.
  - 111 HLT.
- FSM states: IDLE, FETCH, DECODE, FETCH_OP, OPERAND, EXEC, HALT.
- IDLE: outputs quiescent; run=1 -> FETCH.
- FETCH: rom_addr=pc -> DECODE.
- DECODE: IR<=rom_data, pc<=pc+1.
  - Two-byte op -> FETCH_OP.
  - HLT -> HALT.
  - Otherwise -> EXEC.
- FETCH_OP: rom_addr=pc (already incremented) -> OPERAND.
- OPERAND: imm<=rom_data, pc<=pc+1 -> EXEC.
- EXEC, all strobes for exactly this one cycle, then -> FETCH:
  - ALU: f=IR[4:2], write_cz=IR[0], load_a=~dst, load_b=dst.
  - LDI: imm_en=1, f=001 (pass bBus), load_a/load_b per dst, write_cz=0.
  - JMP: pc<=imm.
  - JC: pc<=imm if CF_in=1.
  - JZ: pc<=imm if ZF_in=1.
  - OUT: out_strobe=1.
  - NOP: no strobes.
- Latency: one-byte instruction 3 cycles, two-byte 5 cycles.
- Flag timing: flags written at the end of an ALU EXEC are visible to any later instruction. A JC/JZ sampling them in its own EXEC, at least 4 cycles later, is always correct.
- HALT: halted=1, pc frozen, run ignored; only rst exits.
- Outside EXEC: f=000, all strobes 0; imm holds its last value.
- pc arithmetic is modulo 2^PC_W: 8'hFF+1 wraps to 8'h00, both in DECODE and in OPERAND.
- An operand fetched across the wrap is read from address 0x00.

Test Plan:
- Load and add: rst, run=1; ROM = 20 05 21 03 11.
  - First EXEC: imm=05, imm_en=1, load_a=1.
  - Second EXEC: imm=03, load_b=1.
  - ALU EXEC: f=100, write_cz=1, load_a=1 for exactly one cycle.
  - Cycle count from first FETCH to third EXEC = 13.
- JZ taken: ZF_in=1; ROM[pc]=80 40 -> next rom_addr=0x40.
- JZ not taken: ZF_in=0; JZ at 0x10 -> next rom_addr=0x12.
- JC taken: CF_in=1; ROM 60 20 -> pc=0x20. With CF_in=0 -> pc=0x12.
- OUT then HLT: ROM A0 E0.
  - out_strobe pulses once.
  - halted=1 and rom_addr frozen at 0x02 for 20 cycles despite run toggling.
- PC wrap: JMP FF, ROM[FF]=C0 -> following FETCH presents 0x00.
- Reset mid-EXEC: assert rst during the EXEC of ALU op 11.
  - Next cycle: all strobes 0, pc=0x00, state IDLE.
  - No fetch until run=1.
